// File: rtl/parity_engine.sv
// Serial parity generator/checker: accumulates DATA_WIDTH bits LSB first, produces a
// parity bit in the latched mode, and optionally checks a received parity bit against it.
module parity_engine #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                                  Clock,
   input  logic                                  Reset,
   input  logic [2:0]                            ParityType,
   input  logic                                  Start,
   input  logic                                  Abort,
   input  logic                                  BitValid,
   input  logic                                  BitIn,
   input  logic                                  ParityValid,
   input  logic                                  ParityBitIn,
   output logic                                  Busy,
   output logic                                  ParityOut,
   output logic                                  Done,
   output logic                                  ParityError,
   output logic [$clog2(DATA_WIDTH+1)-1:0]       BitCount
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

   localparam logic [2:0] M_NONE  = 3'd0;
   localparam logic [2:0] M_ODD   = 3'd1;
   localparam logic [2:0] M_EVEN  = 3'd2;
   localparam logic [2:0] M_SPACE = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_WAIT_PAR, S_DONE} state_t;

   state_t           state_q, state_d;
   logic             acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       mode_q, mode_d;
   logic             par_q, par_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Mark and none both drive a 1 so the parity slot idles like a stop bit.
   function automatic logic gen_parity(input logic [2:0] mode, input logic x);
      case (mode)
         M_ODD:   return ~x;
         M_EVEN:  return x;
         M_SPACE: return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      par_d   = par_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) state_d = S_IDLE;
            if (Start) begin
               state_d = S_ACCUM;
               acc_d   = 1'b0;
               cnt_d   = '0;
               err_d   = 1'b0;
               mode_d  = (ParityType > M_SPACE) ? M_NONE : ParityType;
            end
         end
         S_ACCUM: begin
            if (Abort) begin
               state_d = S_IDLE;
            end else if (BitValid) begin
               acc_d = acc_q ^ BitIn;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) begin
                  par_d   = gen_parity(mode_q, acc_q ^ BitIn);
                  state_d = (mode_q == M_NONE) ? S_DONE : S_WAIT_PAR;
               end
            end
         end
         S_WAIT_PAR: begin
            if (Abort) begin
               state_d = S_IDLE;
            end else if (ParityValid) begin
               err_d   = ParityBitIn ^ par_q;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_ACCUM) || (state_d == S_WAIT_PAR);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         acc_q   <= 1'b0;
         cnt_q   <= '0;
         mode_q  <= M_NONE;
         par_q   <= 1'b1;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         par_q   <= par_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Busy        = busy_q;
   assign Done        = done_q;
   assign ParityOut   = par_q;
   assign ParityError = err_q;
   assign BitCount    = cnt_q;

endmodule

// File: tb/tb_parity_engine.sv
// Directed bench for parity_engine at widths 8, 5 and 9 with a queue of expected
// parity/error results consumed at each Done pulse.
module tb_parity_engine;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic [2:0] ParityType = 3'd0;
   logic       Abort = 1'b0;
   logic       BitValid = 1'b0;
   logic       BitIn = 1'b0;
   logic       ParityValid = 1'b0;
   logic       ParityBitIn = 1'b0;
   logic       st8 = 1'b0, st5 = 1'b0, st9 = 1'b0;

   logic       busy8, pout8, done8, perr8;
   logic [3:0] cnt8;
   logic       busy5, pout5, done5, perr5;
   logic [2:0] cnt5;
   logic       busy9, pout9, done9, perr9;
   logic [3:0] cnt9;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic par;
      logic err;
   } exp_t;
   exp_t sbq[$];

   always #5 Clock = ~Clock;

   parity_engine #(.DATA_WIDTH(8)) dut8 (
      .Clock(Clock), .Reset(Reset), .ParityType(ParityType), .Start(st8), .Abort(Abort),
      .BitValid(BitValid), .BitIn(BitIn), .ParityValid(ParityValid), .ParityBitIn(ParityBitIn),
      .Busy(busy8), .ParityOut(pout8), .Done(done8), .ParityError(perr8), .BitCount(cnt8));

   parity_engine #(.DATA_WIDTH(5)) dut5 (
      .Clock(Clock), .Reset(Reset), .ParityType(ParityType), .Start(st5), .Abort(Abort),
      .BitValid(BitValid), .BitIn(BitIn), .ParityValid(ParityValid), .ParityBitIn(ParityBitIn),
      .Busy(busy5), .ParityOut(pout5), .Done(done5), .ParityError(perr5), .BitCount(cnt5));

   parity_engine #(.DATA_WIDTH(9)) dut9 (
      .Clock(Clock), .Reset(Reset), .ParityType(ParityType), .Start(st9), .Abort(Abort),
      .BitValid(BitValid), .BitIn(BitIn), .ParityValid(ParityValid), .ParityBitIn(ParityBitIn),
      .Busy(busy9), .ParityOut(pout9), .Done(done9), .ParityError(perr9), .BitCount(cnt9));

   function automatic int o_busy(int sel);
      return (sel == 5) ? int'(busy5) : (sel == 9) ? int'(busy9) : int'(busy8);
   endfunction
   function automatic int o_done(int sel);
      return (sel == 5) ? int'(done5) : (sel == 9) ? int'(done9) : int'(done8);
   endfunction
   function automatic int o_pout(int sel);
      return (sel == 5) ? int'(pout5) : (sel == 9) ? int'(pout9) : int'(pout8);
   endfunction
   function automatic int o_perr(int sel);
      return (sel == 5) ? int'(perr5) : (sel == 9) ? int'(perr9) : int'(perr8);
   endfunction
   function automatic int o_cnt(int sel);
      return (sel == 5) ? int'(cnt5) : (sel == 9) ? int'(cnt9) : int'(cnt8);
   endfunction

   function automatic logic model_par(input int mode, input logic [8:0] d, input int w);
      logic x = 1'b0;
      for (int i = 0; i < w; i++) x ^= d[i];
      case (mode)
         1:       return ~x;
         2:       return x;
         4:       return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_start(input int sel, input logic [2:0] mode);
      ParityType = mode;
      st8 = (sel == 8);
      st5 = (sel == 5);
      st9 = (sel == 9);
      tick();
      st8 = 1'b0; st5 = 1'b0; st9 = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      BitValid = 1'b1;
      BitIn    = b;
      tick();
      BitValid = 1'b0;
   endtask

   task automatic wait_done(input int sel, input string tag);
      exp_t e;
      int   n = 0;
      while (o_done(sel) != 1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, o_done(sel), 1);
      chk({tag, "_busy_in_done"}, o_busy(sel), 0);
      chk({tag, "_sb_nonempty"}, int'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
         e = sbq.pop_front();
         chk({tag, "_parity_out"}, o_pout(sel), int'(e.par));
         chk({tag, "_parity_err"}, o_perr(sel), int'(e.err));
      end
   endtask

   // Full frame; returns in the DONE cycle so a caller may start back-to-back.
   task automatic run_frame(input int sel, input logic [2:0] mode, input logic [8:0] d,
                            input int w, input logic pb, input bit gaps, input string tag);
      logic p;
      int   m;
      exp_t e;
      m = (mode > 3'd4) ? 0 : int'(mode);
      p = model_par(m, d, w);
      do_start(sel, mode);
      chk({tag, "_busy_start"}, o_busy(sel), 1);
      chk({tag, "_cnt_start"}, o_cnt(sel), 0);
      for (int i = 0; i < w; i++) begin
         if (gaps) repeat ($urandom_range(0, 3)) tick();
         send_bit(d[i]);
      end
      if (m == 0) begin
         e.par = p; e.err = 1'b0;
         sbq.push_back(e);
         wait_done(sel, tag);
      end else begin
         chk({tag, "_busy_waitpar"}, o_busy(sel), 1);
         chk({tag, "_cnt_full"}, o_cnt(sel), w);
         chk({tag, "_pout_waitpar"}, o_pout(sel), int'(p));
         e.par = p; e.err = pb ^ p;
         sbq.push_back(e);
         ParityValid = 1'b1;
         ParityBitIn = pb;
         tick();
         ParityValid = 1'b0;
         wait_done(sel, tag);
      end
   endtask

   initial begin
      logic [8:0] d;
      logic       pb;

      // Reset state
      tick();
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_pout", pout8, 1);
      chk("rst_perr", perr8, 0);
      chk("rst_cnt", cnt8, 0);
      Reset = 1'b0;
      tick();

      // Odd 0xA5 with matching parity bit, then back to IDLE
      run_frame(8, 3'd1, 9'h0A5, 8, 1'b1, 1'b0, "odd_a5");
      tick();
      chk("odd_a5_done_one_cycle", done8, 0);
      chk("odd_a5_idle_busy", busy8, 0);

      // Even 0x07 with ignored mid-frame Start/ParityType and a coincident ParityValid
      d = 9'h007;
      do_start(8, 3'd2);
      for (int i = 0; i < 3; i++) send_bit(d[i]);
      ParityType = 3'd1;
      st8 = 1'b1;
      tick();
      st8 = 1'b0;
      chk("mid_start_cnt", cnt8, 3);
      chk("mid_start_busy", busy8, 1);
      for (int i = 3; i < 7; i++) send_bit(d[i]);
      ParityValid = 1'b1;
      ParityBitIn = 1'b1;
      send_bit(d[7]);
      ParityValid = 1'b0;
      chk("coincident_pv_busy", busy8, 1);
      chk("coincident_pv_done", done8, 0);
      chk("even_07_pout", pout8, 1);
      sbq.push_back('{par: 1'b1, err: 1'b1});
      ParityValid = 1'b1;
      ParityBitIn = 1'b0;
      tick();
      ParityValid = 1'b0;
      wait_done(8, "even_07");
      tick();
      chk("err_hold_1", perr8, 1);
      tick();
      chk("err_hold_2", perr8, 1);
      chk("pout_hold_idle", pout8, 1);

      // Mark with wrong parity bit, then Start in the DONE cycle (space)
      run_frame(8, 3'd3, 9'h05A, 8, 1'b0, 1'b0, "mark_5a");
      run_frame(8, 3'd4, 9'h03C, 8, 1'b0, 1'b0, "space_3c");
      tick();

      // None mode, then 111 treated as none
      run_frame(8, 3'd0, 9'h0FF, 8, 1'b0, 1'b0, "none_ff");
      tick();
      run_frame(8, 3'd7, 9'h000, 8, 1'b0, 1'b0, "type7_00");
      tick();

      // Reset mid-frame after 4 bits
      do_start(8, 3'd2);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      chk("rst_mid_cnt4", cnt8, 4);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("rst_mid_busy", busy8, 0);
      chk("rst_mid_cnt", cnt8, 0);
      chk("rst_mid_done", done8, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_mid_no_done", done8, 0);
      end

      // Abort in WAIT_PAR beats a coincident ParityValid
      do_start(8, 3'd1);
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      chk("abort_waitpar_busy", busy8, 1);
      chk("abort_waitpar_pout", pout8, 1);
      Abort = 1'b1;
      ParityValid = 1'b1;
      ParityBitIn = 1'b0;
      tick();
      Abort = 1'b0;
      ParityValid = 1'b0;
      chk("abort_busy", busy8, 0);
      chk("abort_done", done8, 0);
      chk("abort_perr", perr8, 0);
      tick();
      chk("abort_no_done", done8, 0);
      chk("abort_cnt_held", cnt8, 8);

      // Widths 5 and 9, even mode, random data with gaps
      for (int k = 0; k < 6; k++) begin
         d  = 9'($urandom);
         pb = 1'($urandom);
         run_frame(5, 3'd2, d, 5, pb, 1'b1, "w5_even");
         tick();
         d  = 9'($urandom);
         pb = 1'($urandom);
         run_frame(9, 3'd2, d, 9, pb, 1'b1, "w9_even");
         tick();
      end

      chk("sb_drained", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/parity_engine.md
PARITY_ENGINE -- requirements
Module: parity_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: data bits per frame, legal range 5..9.
REQ-002 SHALL have port Clock, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port ParityType, input, 3 bits: 000 none, 001 odd, 010 even, 011 mark, 100 space; 101..111 are treated as none.
REQ-005 SHALL have port Start, input, 1 bit: begin frame; latches ParityType.
REQ-006 SHALL have port Abort, input, 1 bit: cancel the current frame.
REQ-007 SHALL have port BitValid, input, 1 bit: BitIn is sampled this cycle.
REQ-008 SHALL have port BitIn, input, 1 bit: serial data bit, LSB first.
REQ-009 SHALL have port ParityValid, input, 1 bit: ParityBitIn is sampled this cycle.
REQ-010 SHALL have port ParityBitIn, input, 1 bit: received or transmitted parity bit, used for checking.
REQ-011 SHALL have port Busy, output, 1 bit: high in ACCUM and WAIT_PAR.
REQ-012 SHALL have port ParityOut, output, 1 bit: registered generated parity bit.
REQ-013 SHALL have port Done, output, 1 bit: one-cycle frame-complete pulse.
REQ-014 SHALL have port ParityError, output, 1 bit: registered mismatch flag.
REQ-015 SHALL have port BitCount, output, clog2(DATA_WIDTH+1) bits: data bits accepted in the current frame.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, WAIT_PAR, DONE; DONE lasts exactly one cycle, then IDLE unless Start is asserted.
REQ-017 SHALL accept Start only in IDLE or DONE: next state ACCUM; clear accumulator, BitCount and ParityError; latch ParityType.
REQ-018 SHALL ignore Start in ACCUM and WAIT_PAR, and SHALL ignore ParityType changes after the latch.
REQ-019 SHALL, in ACCUM, XOR BitIn into the accumulator and increment BitCount on each BitValid; BitValid outside ACCUM is ignored, including in the Start cycle.
REQ-020 SHALL, on the cycle the DATA_WIDTH-th bit is accepted, update ParityOut on the next edge and move to WAIT_PAR if the latched mode is not none, else to DONE.
REQ-021 SHALL compute ParityOut per latched mode: odd = NOT(XOR of data); even = XOR of data; mark = 1; none = 1; space = 0.
REQ-022 SHALL hold ParityOut stable from entry to WAIT_PAR/DONE until the next accepted Start, so a transmitter can drive the parity slot from it.
REQ-023 SHALL, in WAIT_PAR, on ParityValid set ParityError to (ParityBitIn XOR ParityOut) on the next edge and move to DONE.
REQ-024 SHALL ignore ParityValid outside WAIT_PAR; a ParityValid coincident with the last BitValid is ignored.
REQ-025 SHALL keep ParityError at 0 in none mode; ParityError holds until the next accepted Start or Reset.
REQ-026 SHALL assert Done for exactly the one cycle spent in DONE; Busy is 0 in IDLE and DONE.
REQ-027 SHALL, on Abort in ACCUM or WAIT_PAR, go to IDLE next edge: no Done, ParityError unchanged; Abort takes priority over BitValid, ParityValid and Start in the same cycle; Abort in IDLE/DONE has no effect.
REQ-028 SHALL hold BitCount at DATA_WIDTH from WAIT_PAR until the next accepted Start (no wrap).

Reset
REQ-029 SHALL, with Reset high at a rising edge, force state IDLE, Busy=0, Done=0, ParityOut=1, ParityError=0, BitCount=0, accumulator=0, latched mode=none.
REQ-030 SHALL give Reset priority over all inputs, including mid-frame; no Done pulse results from an interrupted frame.

Verification
REQ-031 SHALL cover: DATA_WIDTH=8, odd, bits of 0xA5 -> ParityOut=1 at WAIT_PAR entry; ParityBitIn=1 -> Done one cycle later, ParityError=0.
REQ-032 SHALL cover: even, 0x07 -> ParityOut=1; ParityBitIn=0 -> ParityError=1, held until next Start.
REQ-033 SHALL cover: none mode with 0xFF, and ParityType=111 -> DONE directly after 8th bit, ParityOut=1, ParityError=0; space mode -> ParityOut=0.
REQ-034 SHALL cover: Reset after 4 bits -> IDLE, BitCount=0, no Done; Abort in WAIT_PAR -> IDLE, no Done.
REQ-035 SHALL cover: Start in DONE cycle -> back-to-back frame with no IDLE cycle; Start/ParityType change mid-frame ignored.
REQ-036 SHALL cover: DATA_WIDTH=5 and 9 with even mode -> ParityOut equals XOR of the bits for random data, with stimulus gaps between BitValid strobes.
